quad_encoder_counter: RTL and testbench

//  Decodes a quadrature shaft encoder (A/B/Z) into the 10-bit Position word that feeds PWM_Generator.

---
 rtl/qenc_pkg.sv | 61 ++++++
 rtl/qenc_filter.sv | 73 +++++++
 rtl/quad_encoder_counter.sv | 134 +++++++++++++
 tb/tb_quad_encoder_counter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qenc_pkg.sv
// Shared constants and helpers for the quadrature encoder counter.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package qenc_pkg;

    // PPR select codes
    localparam logic [3:0] PR_256  = 4'h0;
    localparam logic [3:0] PR_360  = 4'h4;
    localparam logic [3:0] PR_500  = 4'h8;
    localparam logic [3:0] PR_600  = 4'h9;
    localparam logic [3:0] PR_800  = 4'hC;
    localparam logic [3:0] PR_1024 = 4'hF;

    // Internal edge counter width: 4 edges per line, up to 1024 lines
    localparam int CNT_W = 12;

    // Classification of one A/B sample-to-sample transition
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Lines per revolution for a select code; unknown codes fall back to 1024
    function automatic logic [10:0] ppr_lookup(input logic [3:0] pr);
        logic [10:0] ppr;
        case (pr)
            PR_256:  ppr = 11'd256;
            PR_360:  ppr = 11'd360;
            PR_500:  ppr = 11'd500;
            PR_600:  ppr = 11'd600;
            PR_800:  ppr = 11'd800;
            default: ppr = 11'd1024;
        endcase
        return ppr;
    endfunction

    // Highest legal edge count (4*PPR-1) for a select code
    function automatic logic [CNT_W-1:0] count_max(input logic [3:0] pr);
        return CNT_W'((4 * int'(ppr_lookup(pr))) - 1);
    endfunction

    // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00 on {A,B}
    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_e s;
        s = STEP_NONE;
        if ((prev_ab ^ cur_ab) == 2'b11) begin
            s = STEP_ERR;
        end else if (prev_ab != cur_ab) begin
            case (prev_ab)
                2'b00:   s = (cur_ab == 2'b01) ? STEP_FWD : STEP_REV;
                2'b01:   s = (cur_ab == 2'b11) ? STEP_FWD : STEP_REV;
                2'b11:   s = (cur_ab == 2'b10) ? STEP_FWD : STEP_REV;
                default: s = (cur_ab == 2'b00) ? STEP_FWD : STEP_REV;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/qenc_filter.sv
// Per-channel input conditioner: SYNC_STAGES-flop synchroniser, optional FILT_LEN glitch filter (QENC_GLITCH_FILTER_EN).
// Latency: SYNC_STAGES cycles, plus FILT_LEN cycles when the filter is built in.
// Backpressure: none; free-running sampler.
module qenc_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    // Reject nonsensical configurations at elaboration
    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
        $error("qenc_filter: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced;

    // Shift the asynchronous pin into the synchroniser chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef QENC_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the output; flip after FILT_LEN of them
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (synced != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = filt_q;
`else
    assign dout = synced;
`endif

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature A/B/Z decoder: 4x edge counter with index homing, PPR wrap, direction and sticky error (QENC_GLITCH_FILTER_EN adds input filter).
// Latency: pin edge to Position/step is SYNC_STAGES+1 cycles (+FILT_LEN with the filter).
// Backpressure: none; every decoded edge is applied, step is a single-cycle pulse.
module quad_encoder_counter
    import qenc_pkg::*;
#(
    parameter int POS_W       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_z,
    input  logic [3:0]       PR,
    input  logic             err_clr,
    output logic [POS_W-1:0] Position,
    output logic             dir,
    output logic             step,
    output logic             pos_valid,
    output logic             err
);

    logic a_s, b_s, z_s;

    qenc_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rst_n(reset), .din(enc_a), .dout(a_s)
    );
    qenc_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rst_n(reset), .din(enc_b), .dout(b_s)
    );
    qenc_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
        .clk(clk), .rst_n(reset), .din(enc_z), .dout(z_s)
    );

    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       prev_ab_q, prev_ab_d;
    logic [3:0]       pr_q, pr_d;
    logic             init_q, init_d;
    logic             z_prev_q, z_prev_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             pos_valid_q, pos_valid_d;
    logic             err_q, err_d;

    logic [1:0]       ab;
    logic [CNT_W-1:0] cnt_max;
    logic             pr_change;
    logic             index_hit;
    step_e            st;

    assign ab = {a_s, b_s};

    // Decode the transition and resolve PR change > index > step priority
    always_comb begin
        init_d      = 1'b0;
        prev_ab_d   = ab;
        z_prev_d    = z_s;
        pr_d        = PR;
        count_d     = count_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        pos_valid_d = pos_valid_q;
        err_d       = err_q;

        cnt_max   = count_max(pr_q);
        pr_change = (PR != pr_q);
        index_hit = z_s && !z_prev_q && (ab == 2'b11);
        st        = decode_step(prev_ab_q, ab);

        if (err_clr) begin
            err_d = 1'b0;
        end

        if (pr_change) begin
            count_d     = '0;
            pos_valid_d = 1'b0;
        end

        // The first sample after reset only seeds prev_ab
        if (!init_q) begin
            if (st == STEP_ERR) begin
                err_d = 1'b1;
            end
            if (!pr_change) begin
                if (index_hit) begin
                    count_d     = '0;
                    pos_valid_d = 1'b1;
                end else if (st == STEP_FWD) begin
                    count_d = (count_q == cnt_max) ? '0 : count_q + CNT_W'(1);
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                end else if (st == STEP_REV) begin
                    count_d = (count_q == '0) ? cnt_max : count_q - CNT_W'(1);
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                end
            end
        end
    end

    // Decoder and counter state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            prev_ab_q   <= 2'b00;
            pr_q        <= 4'h0;
            init_q      <= 1'b1;
            z_prev_q    <= 1'b0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            pos_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            prev_ab_q   <= prev_ab_d;
            pr_q        <= pr_d;
            init_q      <= init_d;
            z_prev_q    <= z_prev_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            pos_valid_q <= pos_valid_d;
            err_q       <= err_d;
        end
    end

    assign Position  = POS_W'(count_q[CNT_W-1:2]);
    assign dir       = dir_q;
    assign step      = step_q;
    assign pos_valid = pos_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Self-checking bench for quad_encoder_counter against a pin-level behavioural model.
// Latency: checks wait a fixed settle window after each stimulus.
// Backpressure: n/a.
module tb_quad_encoder_counter;

    localparam int SYNC = 2;
    localparam int FILT = 4;
`ifdef QENC_GLITCH_FILTER_EN
    localparam int HOLD   = FILT + 2;
    localparam int SETTLE = FILT + 6;
`else
    localparam int HOLD   = 3;
    localparam int SETTLE = 5;
`endif

    logic       clk;
    logic       reset;
    logic       enc_a, enc_b, enc_z;
    logic [3:0] PR;
    logic       err_clr;
    logic [9:0] Position;
    logic       dir, step, pos_valid, err;

    quad_encoder_counter #(.POS_W(10), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .PR(PR), .err_clr(err_clr), .Position(Position), .dir(dir), .step(step),
        .pos_valid(pos_valid), .err(err)
    );

    initial begin
        clk = 1'b0;
        #3;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int step_seen = 0;

    // Reference model state (pin-level view of the encoder)
    int m_count, m_dir, m_err, m_pv, m_steps, phase, ppr, cur_pr;

    always @(negedge clk) begin
        if (step === 1'b1) step_seen <= step_seen + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int ppr_of(input int code);
        case (code)
            0:  return 256;
            4:  return 360;
            8:  return 500;
            9:  return 600;
            12: return 800;
            default: return 1024;
        endcase
    endfunction

    task automatic drive_ab();
        logic [1:0] p;
        p = 2'(phase);
        enc_a = p[1];
        enc_b = p[1] ^ p[0];
    endtask

    task automatic move(input bit fwd);
        @(negedge clk);
        if (fwd) begin
            phase   = (phase + 1) % 4;
            m_count = (m_count + 1) % (4 * ppr);
            m_dir   = 1;
        end else begin
            phase   = (phase + 3) % 4;
            m_count = (m_count + 4 * ppr - 1) % (4 * ppr);
            m_dir   = 0;
        end
        m_steps++;
        drive_ab();
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic illegal();
        @(negedge clk);
        phase = (phase + 2) % 4;
        m_err = 1;
        drive_ab();
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 0;
    endtask

    task automatic set_pr(input int code);
        @(negedge clk);
        if (code != cur_pr) begin
            m_count = 0;
            m_pv    = 0;
        end
        cur_pr = code;
        ppr    = ppr_of(code);
        PR     = 4'(code);
        repeat (HOLD) @(negedge clk);
    endtask

    // Only called with A=B=1 on the pins
    task automatic index_pulse();
        @(negedge clk);
        enc_z   = 1'b1;
        m_count = 0;
        m_pv    = 1;
        repeat (HOLD) @(negedge clk);
        enc_z = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        repeat (SETTLE) @(negedge clk);
        #1;
        chk({tag, ".pos"},   int'(Position),  m_count / 4);
        chk({tag, ".dir"},   int'(dir),       m_dir);
        chk({tag, ".err"},   int'(err),       m_err);
        chk({tag, ".pv"},    int'(pos_valid), m_pv);
        chk({tag, ".steps"}, step_seen,       m_steps);
    endtask

    task automatic model_reset();
        m_count = 0; m_dir = 0; m_err = 0; m_pv = 0; phase = 0;
    endtask

    initial begin
        int base;
        int op;
        logic [1:0] save;

        reset = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        PR = 4'h9; err_clr = 1'b0;
        cur_pr = 9; ppr = 600; m_steps = 0;
        model_reset();

        // Reset values
        #50;
        chk("rst.pos",  int'(Position),  0);
        chk("rst.dir",  int'(dir),       0);
        chk("rst.step", int'(step),      0);
        chk("rst.pv",   int'(pos_valid), 0);
        chk("rst.err",  int'(err),       0);
        #75;
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 8 forward cycles = 32 edges
        base = step_seen;
        for (int i = 0; i < 32; i++) move(1'b1);
        check_all("fwd32");
        chk("fwd32.pulses", step_seen - base, 32);

        // Wrap at 4*600 in both directions
        set_pr(4);
        set_pr(9);
        move(1'b0);
        check_all("wrap_rev");
        chk("wrap_rev.pos599", int'(Position), 599);
        move(1'b1);
        check_all("wrap_fwd");
        move(1'b0);
        check_all("wrap_rev2");

        // Illegal transition is sticky until cleared
        illegal();
        check_all("illegal");
        move(1'b1);
        check_all("illegal_sticky");
        clear_err();
        #1;
        chk("errclr.next", int'(err), 0);
        check_all("errclr");

        // Index homing at count 137 with A=B=1
        while (phase != 1) move(1'b1);
        set_pr(0);
        set_pr(9);
        for (int i = 0; i < 137; i++) move(1'b1);
        check_all("pre_index");
        index_pulse();
        check_all("index");

        // Index coincident with an A/B edge: index wins, no step
        set_pr(8);
        set_pr(9);
        move(1'b0);
        check_all("pre_coinc");
        @(negedge clk);
        phase = 2;
        drive_ab();
        enc_z   = 1'b1;
        m_count = 0;
        m_pv    = 1;
        repeat (HOLD) @(negedge clk);
        enc_z = 1'b0;
        check_all("coinc");

        // PR change at Position 300, then full 1024-line revolution
        for (int i = 0; i < 1200; i++) move(1'b1);
        check_all("pos300");
        set_pr(15);
        check_all("pr_chg");
        for (int i = 0; i < 4095; i++) move(1'b1);
        check_all("rev4095");
        move(1'b1);
        check_all("rev4096");

        // Short glitch on the leading channel
        base = step_seen;
        @(negedge clk);
        save  = {enc_a, enc_b};
        phase = (phase + 1) % 4;
        drive_ab();
        repeat (2) @(negedge clk);
        phase = (phase + 3) % 4;
        enc_a = save[1];
        enc_b = save[0];
`ifndef QENC_GLITCH_FILTER_EN
        m_steps += 2;
        m_dir = 0;
`endif
        check_all("glitch");
        move(1'b1);
        check_all("stable_edge");
`ifdef QENC_GLITCH_FILTER_EN
        chk("glitch.pulses", step_seen - base, 1);
`else
        chk("glitch.pulses", step_seen - base, 3);
`endif

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 11));
            if (op <= 4) move(1'b1);
            else if (op <= 6) move(1'b0);
            else if (op == 7) illegal();
            else if (op == 8) clear_err();
            else if (op == 9) set_pr(int'($urandom_range(0, 15)));
            else if (phase == 2) index_pulse();
            else move(1'b1);
            check_all("rnd");
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.pos",  int'(Position),  0);
        chk("arst.dir",  int'(dir),       0);
        chk("arst.pv",   int'(pos_valid), 0);
        chk("arst.err",  int'(err),       0);
        chk("arst.step", int'(step),      0);
        enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        model_reset();
        repeat (SETTLE) @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (SETTLE) @(negedge clk);
        for (int i = 0; i < 6; i++) move(1'b1);
        check_all("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
